// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared types and constants for the way-halting tag lookup controller.
// Holds the sequencer state encoding, address field positions and tag widths.
package tag_ctrl_pkg;

  localparam int ADDR_W     = 32;
  localparam int MAIN_LSB   = 28;
  localparam int HALT_LSB   = 8;
  localparam int IDX_LSB    = 4;
  localparam int LINE_LSB   = 4;
  localparam int MAIN_TAG_W = 4;
  localparam int HALT_TAG_W = 20;
  localparam int IDX_BITS   = 4;

  typedef enum logic [2:0] {
    IDLE, HALT, MAIN, MISS_REQ, MISS_WAIT, FILL, RESP
  } state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// CPU, tag-array and refill signals of the tag lookup controller.
// master = controller side, slave = CPU / tag arrays / memory side.
interface tag_lookup_ctrl_if #(
  parameter int N_WAYS = 4,
  parameter int IDX_W  = 4,
  parameter int HALT_W = 20,
  parameter int MAIN_W = 4
);
  localparam int WAY_W = $clog2(N_WAYS);

  logic                     cpu_req;
  logic [31:0]              cpu_addr;
  logic                     cpu_ready;
  logic                     cpu_resp_valid;
  logic                     cpu_hit;
  logic [WAY_W-1:0]         cpu_way;
  logic                     flush;
  logic [IDX_W-1:0]         tag_index;
  logic [N_WAYS*MAIN_W-1:0] tag_rd_main;
  logic [N_WAYS*HALT_W-1:0] tag_rd_halt;
  logic                     tag_we;
  logic [N_WAYS-1:0]        tag_way_sel;
  logic [MAIN_W-1:0]        tag_wr_main;
  logic [HALT_W-1:0]        tag_wr_halt;
  logic                     mem_req;
  logic [31:0]              mem_addr;
  logic                     mem_ack;

  modport master (
    input  cpu_req, cpu_addr, flush, tag_rd_main, tag_rd_halt, mem_ack,
    output cpu_ready, cpu_resp_valid, cpu_hit, cpu_way, tag_index,
           tag_we, tag_way_sel, tag_wr_main, tag_wr_halt, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, flush, tag_rd_main, tag_rd_halt, mem_ack,
    input  cpu_ready, cpu_resp_valid, cpu_hit, cpu_way, tag_index,
           tag_we, tag_way_sel, tag_wr_main, tag_wr_halt, mem_req, mem_addr
  );
endinterface

// File: rtl/tag_victim_sel.sv
// Refill victim choice: lowest invalid way, else the set's round-robin pointer.
// rr_used tells the caller whether the pointer should advance.
module tag_victim_sel #(
  parameter int N_WAYS = 4,
  parameter int WAY_W  = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]  rr,
  output logic [N_WAYS-1:0] victim,
  output logic              rr_used
);
  always_comb begin
    victim  = '0;
    rr_used = 1'b1;
    for (int w = N_WAYS-1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim    = '0;
        victim[w] = 1'b1;
        rr_used   = 1'b0;
      end
    end
    if (rr_used) victim[rr] = 1'b1;
  end
endmodule

// File: rtl/tag_lookup_ctrl.sv
// Way-halting tag lookup sequencer: halt-tag filter, main-tag compare, refill.
// Optional TAG_CTRL_PERF_CNT_EN adds saturating hit/miss/halt-save counters.
module tag_lookup_ctrl
  import tag_ctrl_pkg::*;
#(
  parameter int N_WAYS = 4,
  parameter int N_SETS = 16,
  parameter int IDX_W  = IDX_BITS,
  parameter int HALT_W = HALT_TAG_W,
  parameter int MAIN_W = MAIN_TAG_W
) (
  input  logic clk,
  input  logic reset,
  tag_lookup_ctrl_if.master bus
`ifdef TAG_CTRL_PERF_CNT_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic [15:0] halt_save_cnt
`endif
);
  localparam int WAY_W = $clog2(N_WAYS);

  state_t                         state;
  logic [31:LINE_LSB]             line_q;
  logic [N_WAYS-1:0]              halt_mask, halt_cmp, match, victim_oh;
  logic [N_SETS-1:0][N_WAYS-1:0]  valid;
  logic [N_SETS-1:0][WAY_W-1:0]   rr;
  logic [WAY_W-1:0]               hit_way, victim_idx, fill_way;
  logic [IDX_W-1:0]               idx;
  logic [MAIN_W-1:0]              main_tag;
  logic [HALT_W-1:0]              halt_tag;
  logic                           rr_used;

  assign idx             = line_q[IDX_LSB +: IDX_W];
  assign main_tag        = line_q[MAIN_LSB +: MAIN_W];
  assign halt_tag        = line_q[HALT_LSB +: HALT_W];
  assign bus.tag_index   = idx;
  assign bus.tag_wr_main = main_tag;
  assign bus.tag_wr_halt = halt_tag;
  assign bus.cpu_ready   = (state == IDLE) && !bus.flush;

  always_comb begin
    halt_cmp   = '0;
    match      = '0;
    hit_way    = '0;
    victim_idx = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      halt_cmp[w] = valid[idx][w] && (bus.tag_rd_halt[w*HALT_W +: HALT_W] == halt_tag);
      match[w]    = halt_mask[w] && (bus.tag_rd_main[w*MAIN_W +: MAIN_W] == main_tag);
    end
    for (int w = N_WAYS-1; w >= 0; w--)
      if (match[w]) hit_way = WAY_W'(w);
    for (int w = 0; w < N_WAYS; w++)
      if (victim_oh[w]) victim_idx = WAY_W'(w);
  end

  tag_victim_sel #(.N_WAYS(N_WAYS), .WAY_W(WAY_W)) u_victim (
    .valid   (valid[idx]),
    .rr      (rr[idx]),
    .victim  (victim_oh),
    .rr_used (rr_used)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      line_q             <= '0;
      halt_mask          <= '0;
      valid              <= '0;
      rr                 <= '0;
      fill_way           <= '0;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_hit        <= 1'b0;
      bus.cpu_way        <= '0;
      bus.tag_we         <= 1'b0;
      bus.tag_way_sel    <= '0;
      bus.mem_req        <= 1'b0;
      bus.mem_addr       <= '0;
    end else begin
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_hit        <= 1'b0;
      bus.cpu_way        <= '0;
      bus.tag_we         <= 1'b0;
      bus.tag_way_sel    <= '0;
      case (state)
        IDLE: begin
          if (bus.flush) valid <= '0;
          else if (bus.cpu_req) begin
            line_q <= bus.cpu_addr[31:LINE_LSB];
            state  <= HALT;
          end
        end
        HALT: begin
          halt_mask <= halt_cmp;
          state     <= MAIN;
        end
        MAIN: begin
          if (|match) begin
            bus.cpu_resp_valid <= 1'b1;
            bus.cpu_hit        <= 1'b1;
            bus.cpu_way        <= hit_way;
            state              <= RESP;
          end else state <= MISS_REQ;
        end
        // mem_req rises on entry to MISS_WAIT so an ack in its first cycle is seen
        MISS_REQ: begin
          bus.mem_req  <= 1'b1;
          bus.mem_addr <= {line_q, {LINE_LSB{1'b0}}};
          state        <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req     <= 1'b0;
            bus.tag_we      <= 1'b1;
            bus.tag_way_sel <= victim_oh;
            valid[idx]      <= valid[idx] | victim_oh;
            if (rr_used) rr[idx] <= rr[idx] + WAY_W'(1);
            fill_way        <= victim_idx;
            state           <= FILL;
          end
        end
        FILL: begin
          bus.cpu_resp_valid <= 1'b1;
          bus.cpu_way        <= fill_way;
          state              <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TAG_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      halt_save_cnt <= '0;
    end else if (state == IDLE && bus.flush) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      halt_save_cnt <= '0;
    end else begin
      if (state == RESP && bus.cpu_hit)  hit_cnt  <= sat_add16(hit_cnt, 16'd1);
      if (state == RESP && !bus.cpu_hit) miss_cnt <= sat_add16(miss_cnt, 16'd1);
      if (state == MAIN)
        halt_save_cnt <= sat_add16(halt_save_cnt, 16'(N_WAYS - $countones(halt_mask)));
    end
  end
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural tag array and refill responder.
// Define TAG_CTRL_PERF_CNT_EN to also exercise the performance counters.
module tb_tag_lookup_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tag_lookup_ctrl_if #(.N_WAYS(4), .IDX_W(4), .HALT_W(20), .MAIN_W(4)) bus();
`ifdef TAG_CTRL_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt, halt_save_cnt;
`endif

  tag_lookup_ctrl #(.N_WAYS(4), .N_SETS(16), .IDX_W(4), .HALT_W(20), .MAIN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef TAG_CTRL_PERF_CNT_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .halt_save_cnt (halt_save_cnt)
`endif
  );

  logic [3:0]  tm_main [16][4];
  logic [19:0] tm_halt [16][4];

  initial begin
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        tm_main[s][w] = '0;
        tm_halt[s][w] = '0;
      end
  end

  always @(posedge clk)
    if (bus.tag_we)
      for (int w = 0; w < 4; w++)
        if (bus.tag_way_sel[w]) begin
          tm_main[bus.tag_index][w] <= bus.tag_wr_main;
          tm_halt[bus.tag_index][w] <= bus.tag_wr_halt;
        end

  always_comb begin
    bus.tag_rd_main = '0;
    bus.tag_rd_halt = '0;
    for (int w = 0; w < 4; w++) begin
      bus.tag_rd_main[w*4 +: 4]   = tm_main[bus.tag_index][w];
      bus.tag_rd_halt[w*20 +: 20] = tm_halt[bus.tag_index][w];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one lookup, answers any refill after ack_dly cycles of mem_req, returns observations.
  task automatic lookup(input logic [31:0] addr, input int ack_dly,
                        output logic hit, output logic [1:0] way, output int cyc,
                        output logic saw_mreq, output logic [31:0] maddr,
                        output logic [3:0] sel, output logic [3:0] wmain, output logic [19:0] whalt);
    int  wait_n;
    bit  done;
    hit = 0; way = 0; cyc = 0; saw_mreq = 0; maddr = 0; sel = 0; wmain = 0; whalt = 0;
    wait_n = 0; done = 0;
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      else if (bus.mem_req) begin
        if (!saw_mreq) maddr = bus.mem_addr;
        saw_mreq = 1'b1;
        wait_n++;
        if (wait_n == ack_dly) bus.mem_ack = 1'b1;
      end
      if (bus.tag_we) begin
        sel   = bus.tag_way_sel;
        wmain = bus.tag_wr_main;
        whalt = bus.tag_wr_halt;
      end
      if (bus.cpu_resp_valid) begin
        hit  = bus.cpu_hit;
        way  = bus.cpu_way;
        done = 1'b1;
      end
    end
    chk("resp_seen", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  logic        hit, smr;
  logic [1:0]  way;
  logic [3:0]  sel, wm;
  logic [19:0] wh;
  logic [31:0] ma;
  int          cyc;
  logic [31:0] set7 [6];
  int          set7_way [6];
  bit          bad;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_req = 0; bus.cpu_addr = 0; bus.flush = 0; bus.mem_ack = 0;
    set7 = '{32'h1000_0170, 32'h2000_0171, 32'h1000_0272, 32'h3ABC_DE7B,
             32'h4000_0174, 32'h5000_0175};
    set7_way = '{0, 1, 2, 3, 0, 1};
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", 64'(bus.cpu_ready), 64'd1);
    chk("rst_resp",  64'(bus.cpu_resp_valid), 64'd0);
    chk("rst_mreq",  64'(bus.mem_req), 64'd0);
    chk("rst_we",    64'(bus.tag_we), 64'd0);
    chk("rst_index", 64'(bus.tag_index), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // cold miss with a 5-cycle refill
    lookup(32'h1234_5670, 5, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("t1_mreq",  64'(smr), 64'd1);
    chk("t1_maddr", 64'(ma), 64'h1234_5670);
    chk("t1_sel",   64'(sel), 64'b0001);
    chk("t1_wmain", 64'(wm), 64'h1);
    chk("t1_whalt", 64'(wh), 64'h23456);
    chk("t1_hit",   64'(hit), 64'd0);
    chk("t1_way",   64'(way), 64'd0);

    // same line: hit, response visible after the 2nd edge and sampled on the 3rd
    lookup(32'h1234_5670, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("t2_hit",  64'(hit), 64'd1);
    chk("t2_way",  64'(way), 64'd0);
    chk("t2_lat",  64'(cyc), 64'd2);
    chk("t2_mreq", 64'(smr), 64'd0);
    lookup(32'h1234_567C, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("t2_ofs_hit", 64'(hit), 64'd1);

    // flush beats a simultaneous request
    bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h9999_9990;
    #1 chk("fl_ready", 64'(bus.cpu_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.cpu_req = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.cpu_resp_valid || bus.mem_req || !bus.cpu_ready) bad = 1;
    end
    chk("fl_no_accept", 64'(bad), 64'd0);
    lookup(32'h1234_5670, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("fl_miss", 64'(hit), 64'd0);
    chk("fl_mreq", 64'(smr), 64'd1);
    chk("fl_sel",  64'(sel), 64'b0001);

    // set 7: four invalid-way fills then round-robin
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lookup(set7[i], 2, hit, way, cyc, smr, ma, sel, wm, wh);
      chk($sformatf("s7_hit%0d", i),   64'(hit), 64'd0);
      chk($sformatf("s7_way%0d", i),   64'(way), 64'(set7_way[i]));
      chk($sformatf("s7_sel%0d", i),   64'(sel), 64'(4'b0001 << set7_way[i]));
      chk($sformatf("s7_maddr%0d", i), 64'(ma),  64'(set7[i] & 32'hFFFF_FFF0));
    end
    lookup(32'h1000_0270, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("s7_hit_w2", 64'(hit), 64'd1);
    chk("s7_way_w2", 64'(way), 64'd2);
    // halt tag matches ways 0/1 but main tags differ: miss, rr now points at way 2
    lookup(32'h1000_0170, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("s7_evict_hit", 64'(hit), 64'd0);
    chk("s7_evict_way", 64'(way), 64'd2);
    lookup(32'h3ABC_DE70, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("s7_hit_w3", 64'(hit), 64'd1);
    chk("s7_way_w3", 64'(way), 64'd3);

    // reset while waiting for refill
    bus.cpu_addr = 32'h7777_7770; bus.cpu_req = 1'b1;
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    cyc = 0;
    while (!bus.mem_req && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rw_mreq_up", 64'(bus.mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rw_mreq_async", 64'(bus.mem_req), 64'd0);
    chk("rw_ready_rst",  64'(bus.cpu_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.cpu_resp_valid || bus.mem_req) bad = 1;
    end
    chk("rw_no_resp", 64'(bad), 64'd0);
    chk("rw_ready",   64'(bus.cpu_ready), 64'd1);
    lookup(32'h1234_5670, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("rw_miss", 64'(hit), 64'd0);
    chk("rw_sel",  64'(sel), 64'b0001);

`ifdef TAG_CTRL_PERF_CNT_EN
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    chk("pc_rst_hit", 64'(hit_cnt), 64'd0);
    lookup(32'h1234_5670, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    lookup(32'h5000_0130, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    lookup(32'h1234_5670, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    lookup(32'h5000_0130, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    lookup(32'h1234_5670, 1, hit, way, cyc, smr, ma, sel, wm, wh);
    chk("pc_hit",  64'(hit_cnt), 64'd3);
    chk("pc_miss", 64'(miss_cnt), 64'd2);
    // two misses mask all 4 ways, three hits mask 3 ways each
    chk("pc_halt", 64'(halt_save_cnt), 64'd17);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("pc_flush_hit",  64'(hit_cnt), 64'd0);
    chk("pc_flush_miss", 64'(miss_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
- Sequencer for the way-halting cache tag store.
- Accepts CPU lookups and drives the set index to the main and halt tag arrays.
- Runs a two-stage compare: halt-tag filter first, then main-tag compare on surviving ways only.
- On a miss, runs a memory-refill handshake, then writes the new tags into the victim way.
- Owns the per-set valid bits and the per-set round-robin replacement pointers.

Parameters:
- N_WAYS, 4, number of ways; power of two, 2..8.
- N_SETS, 16, number of sets; power of two.
- IDX_W, 4, log2(N_SETS).
- HALT_W, 20, halt tag width.
- MAIN_W, 4, main tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  lookup request.
- cpu_addr  in  32  lookup address: [31:28] main tag, [27:8] halt tag, [7:4] index, [3:0] offset (ignored).
- cpu_ready  out  1  high when a request can be accepted.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_hit  out  1  1 = hit, 0 = miss that has since been filled.
- cpu_way  out  log2(N_WAYS)  way that hit or was filled.
- flush  in  1  invalidate all lines.
- tag_index  out  IDX_W  set index presented to the tag arrays.
- tag_rd_main  in  N_WAYS*MAIN_W  main tags of the indexed set; way w at [w*MAIN_W +: MAIN_W].
- tag_rd_halt  in  N_WAYS*HALT_W  halt tags of the indexed set, same packing.
- tag_we  out  1  tag-array write enable (regWrite).
- tag_way_sel  out  N_WAYS  one-hot way select (decOut) for the write.
- tag_wr_main  out  MAIN_W  main tag to write.
- tag_wr_halt  out  HALT_W  halt tag to write.
- mem_req  out  1  refill request.
- mem_addr  out  32  line address, offset bits forced to 0.
- mem_ack  in  1  refill complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; all valid bits and RR pointers = 0.
  - All outputs 0 except cpu_ready = 1.
  - Any request in flight is dropped with no response.
  - mem_req falls immediately.
- IDLE:
  - cpu_ready = 1 unless flush = 1.
  - On cpu_req & cpu_ready: latch the address; tag_index = latched index, held until RESP completes; go to HALT.
  - flush = 1 in IDLE: clear all valid bits this edge and stay in IDLE. flush wins over a simultaneous cpu_req, which is not accepted.
  - flush outside IDLE is ignored; the requester must hold it.
- HALT (1 cycle):
  - Register halt_mask[w] = valid[idx][w] & (halt tag of way w == latched halt tag).
  - Go to MAIN.
- MAIN (1 cycle):
  - match[w] = halt_mask[w] & (main tag of way w == latched main tag).
  - Any match: record the lowest matching way; go to RESP with hit = 1.
  - No match: go to MISS_REQ.
  - Hit latency: response pulse on the 3rd edge after acceptance.
- MISS_REQ / MISS_WAIT:
  - mem_req = 1 with a stable mem_addr until the cycle mem_ack = 1 is sampled.
  - mem_ack arriving in the same cycle mem_req first rises is legal.
  - mem_ack outside MISS_WAIT is ignored.
  - Then go to FILL.
- FILL (1 cycle):
  - Victim = first invalid way (lowest index) in the set; otherwise rr[idx].
  - tag_we = 1 with tag_way_sel = one-hot victim and the latched tags on the write ports.
  - Set valid[idx][victim].
  - rr[idx] increments modulo N_WAYS only when the RR pointer chose the victim.
  - Go to RESP with hit = 0.
- RESP (1 cycle):
  - cpu_resp_valid = 1; cpu_hit and cpu_way valid this cycle only.
  - Go to IDLE; the next request is accepted the following cycle.
- Valid bits and RR pointers are controller flops; the tag arrays hold tags only.
- Multiple main-tag matches cannot occur after correct fills; the lowest way wins regardless.

Optional Feature:
- Macro: TAG_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[15:0] and miss_cnt[15:0], saturating at 16'hFFFF.
  - hit_cnt increments on RESP with hit = 1; miss_cnt increments on RESP with hit = 0.
  - Also adds halt_save_cnt[15:0], incremented in MAIN by the number of ways masked off by halt_mask (saturating).
  - All counters reset to 0 and are cleared by flush.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package tag_ctrl_pkg holds:
  - state enum: IDLE, HALT, MAIN, MISS_REQ, MISS_WAIT, FILL, RESP;
  - address field position constants;
  - tag width constants.
- One sub-module, tag_victim_sel:
  - combinational;
  - inputs: valid vector and RR pointer;
  - outputs: one-hot victim and an "rr_used" flag.

Test Plan:
- After reset, cpu_req with addr 32'h1234_5670 -> miss: mem_req rises, mem_addr = 32'h1234_5670. mem_ack after 5 cycles -> FILL writes way 0 with main 4'h1, halt 20'h23456, tag_way_sel = 4'b0001; resp cpu_hit = 0, cpu_way = 0.
- Repeat the same address (tag model returns the written tags) -> cpu_resp_valid on the 3rd edge, cpu_hit = 1, cpu_way = 0, no mem_req.
- Five distinct tags in set 7 -> fills go to ways 0, 1, 2, 3, then way 0 via RR; rr[7] = 1 afterwards.
- flush and cpu_req high in the same IDLE cycle -> cpu_ready = 0, request not accepted, all valids clear; the next lookup misses.
- reset asserted during MISS_WAIT -> mem_req falls asynchronously, no cpu_resp_valid, cpu_ready = 1 after release.
- With TAG_CTRL_PERF_CNT_EN defined: 3 hits and 2 misses -> hit_cnt = 3, miss_cnt = 2.
